// File: rtl/hpdcache_fifo_reg_preload.sv
// hpdcache_fifo_reg_preload: register FIFO preloaded from initial_value_i on reset/flush, with partial occupancy.
// Optional HPDCACHE_FIFO_PRELOAD_STATS_EN adds max_count_o high-water mark and sticky err_o.
module hpdcache_fifo_reg_preload #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter type         fifo_data_t   = logic,
    parameter int unsigned INIT_COUNT    = FIFO_DEPTH,
    parameter int unsigned AEMPTY_THRESH = 1,
    parameter bit          FEED_THROUGH  = 1'b0,
    localparam int unsigned PW = $clog2(FIFO_DEPTH),
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            w_i,
    output logic            wok_o,
    input  fifo_data_t      wdata_i,
    input  logic            r_i,
    output logic            rok_o,
    output fifo_data_t      rdata_o,
    input  fifo_data_t      initial_value_i [FIFO_DEPTH],
    output logic [CW-1:0]   count_o,
`ifdef HPDCACHE_FIFO_PRELOAD_STATS_EN
    output logic [CW-1:0]   max_count_o,
    output logic            err_o,
`endif
    output logic            aempty_o
);
    localparam logic [PW-1:0] WPTR_INIT = PW'(INIT_COUNT % FIFO_DEPTH);

    fifo_data_t    mem [FIFO_DEPTH];
    logic [PW-1:0] rptr, wptr;
    logic [CW-1:0] count, count_d;
    logic          empty, full, bypass, wexec, rexec, load;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign wok_o    = ~full & ~flush_i;
    assign rok_o    = (~empty | (FEED_THROUGH & w_i)) & ~flush_i;
    // A write into an empty feed-through FIFO that is read in the same cycle never touches storage.
    assign bypass   = FEED_THROUGH & empty & w_i & r_i & ~flush_i;
    assign wexec    = w_i & wok_o & ~bypass;
    assign rexec    = r_i & rok_o & ~bypass;
    assign rdata_o  = (FEED_THROUGH && empty) ? wdata_i : mem[rptr];
    assign count_o  = count;
    assign aempty_o = 32'(count) <= AEMPTY_THRESH;
    assign load     = ~rst_ni | flush_i;

    always_comb begin
        count_d = (wexec & ~rexec) ? count + 1'b1 : (rexec & ~wexec) ? count - 1'b1 : count;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr  <= '0;
            wptr  <= WPTR_INIT;
            count <= CW'(INIT_COUNT);
        end else if (flush_i) begin
            rptr  <= '0;
            wptr  <= WPTR_INIT;
            count <= CW'(INIT_COUNT);
        end else begin
            if (wexec) wptr <= inc(wptr);
            if (rexec) rptr <= inc(rptr);
            count <= count_d;
        end
    end

    // Storage has no async reset; it reloads on every edge seen with reset or flush active.
    always_ff @(posedge clk_i) begin
        if (load) mem <= initial_value_i;
        else if (wexec) mem[wptr] <= wdata_i;
    end

`ifdef HPDCACHE_FIFO_PRELOAD_STATS_EN
    logic [CW-1:0] max_count;
    logic          err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            max_count <= CW'(INIT_COUNT);
            err       <= 1'b0;
        end else if (flush_i) begin
            max_count <= CW'(INIT_COUNT);
            err       <= 1'b0;
        end else begin
            max_count <= (count_d > max_count) ? count_d : max_count;
            err       <= err | (w_i & ~wok_o) | (r_i & ~rok_o);
        end
    end

    assign max_count_o = max_count;
    assign err_o       = err;
`endif

`ifndef SYNTHESIS
    if (INIT_COUNT > FIFO_DEPTH) begin : g_bad_init
        $error("INIT_COUNT must not exceed FIFO_DEPTH");
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("FIFO_DEPTH must be at least 2");
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(wexec && full));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(rexec && empty && !FEED_THROUGH));
    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni) 32'(count) <= FIFO_DEPTH);
    a_ptr_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((32'(wptr) + FIFO_DEPTH - 32'(rptr)) % FIFO_DEPTH) == (32'(count) % FIFO_DEPTH));
`endif
endmodule

// File: tb/tb_hpdcache_fifo_reg_preload.sv
// tb_hpdcache_fifo_reg_preload: directed scoreboard bench over full-preload, partial-preload and feed-through instances.
module tb_hpdcache_fifo_reg_preload;
    typedef logic [7:0] data_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    data_t iv_a [4], iv_b [4], iv_c [4];
    logic  fl_a = 0, w_a = 0, r_a = 0, fl_b = 0, w_b = 0, r_b = 0, fl_c = 0, w_c = 0, r_c = 0;
    data_t wd_a = 0, wd_b = 0, wd_c = 0, rd_a, rd_b, rd_c;
    logic  wok_a, rok_a, ae_a, wok_b, rok_b, ae_b, wok_c, rok_c, ae_c;
    logic [2:0] cnt_a, cnt_b, cnt_c;
`ifdef HPDCACHE_FIFO_PRELOAD_STATS_EN
    logic [2:0] max_a, max_b, max_c;
    logic       err_a, err_b, err_c;
`endif
    data_t qa [$], qb [$], qc [$];

    initial for (int i = 0; i < 4; i++) begin
        iv_a[i] = data_t'(i);
        iv_b[i] = data_t'(8'h10 + i);
        iv_c[i] = data_t'(8'h20 + i);
    end

    hpdcache_fifo_reg_preload #(.FIFO_DEPTH(4), .fifo_data_t(data_t), .INIT_COUNT(4)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl_a), .w_i(w_a), .wok_o(wok_a), .wdata_i(wd_a),
        .r_i(r_a), .rok_o(rok_a), .rdata_o(rd_a), .initial_value_i(iv_a), .count_o(cnt_a),
`ifdef HPDCACHE_FIFO_PRELOAD_STATS_EN
        .max_count_o(max_a), .err_o(err_a),
`endif
        .aempty_o(ae_a));

    hpdcache_fifo_reg_preload #(.FIFO_DEPTH(4), .fifo_data_t(data_t), .INIT_COUNT(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl_b), .w_i(w_b), .wok_o(wok_b), .wdata_i(wd_b),
        .r_i(r_b), .rok_o(rok_b), .rdata_o(rd_b), .initial_value_i(iv_b), .count_o(cnt_b),
`ifdef HPDCACHE_FIFO_PRELOAD_STATS_EN
        .max_count_o(max_b), .err_o(err_b),
`endif
        .aempty_o(ae_b));

    hpdcache_fifo_reg_preload #(.FIFO_DEPTH(4), .fifo_data_t(data_t), .INIT_COUNT(0), .FEED_THROUGH(1'b1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl_c), .w_i(w_c), .wok_o(wok_c), .wdata_i(wd_c),
        .r_i(r_c), .rok_o(rok_c), .rdata_o(rd_c), .initial_value_i(iv_c), .count_o(cnt_c),
`ifdef HPDCACHE_FIFO_PRELOAD_STATS_EN
        .max_count_o(max_c), .err_o(err_c),
`endif
        .aempty_o(ae_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every executed read pops the next expected word for that instance.
    always @(negedge clk) if (rst_n && r_a && rok_a) begin
        if (qa.size() == 0) begin errors++; checks++; $display("FAIL a_rdata: unexpected read got %0h expected none", rd_a); end
        else chk("a_rdata", 32'(rd_a), 32'(qa.pop_front()));
    end
    always @(negedge clk) if (rst_n && r_b && rok_b) begin
        if (qb.size() == 0) begin errors++; checks++; $display("FAIL b_rdata: unexpected read got %0h expected none", rd_b); end
        else chk("b_rdata", 32'(rd_b), 32'(qb.pop_front()));
    end
    always @(negedge clk) if (rst_n && r_c && rok_c) begin
        if (qc.size() == 0) begin errors++; checks++; $display("FAIL c_rdata: unexpected read got %0h expected none", rd_c); end
        else chk("c_rdata", 32'(rd_c), 32'(qc.pop_front()));
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("a_rst_rok", 32'(rok_a), 1); chk("a_rst_wok", 32'(wok_a), 0);
        chk("a_rst_cnt", 32'(cnt_a), 4); chk("a_rst_ae", 32'(ae_a), 0); chk("a_rst_rd", 32'(rd_a), 0);
        chk("b_rst_cnt", 32'(cnt_b), 2); chk("b_rst_wok", 32'(wok_b), 1); chk("b_rst_rok", 32'(rok_b), 1);
        chk("b_rst_ae", 32'(ae_b), 0); chk("b_rst_rd", 32'(rd_b), 8'h10);
        chk("c_rst_cnt", 32'(cnt_c), 0); chk("c_rst_rok", 32'(rok_c), 0);
        chk("c_rst_wok", 32'(wok_c), 1); chk("c_rst_ae", 32'(ae_c), 1);

        // A: drain the full preload
        for (int i = 0; i < 4; i++) qa.push_back(data_t'(i));
        nx(); r_a = 1;
        repeat (4) nx();
        r_a = 0;
        @(negedge clk);
        chk("a_empty_rok", 32'(rok_a), 0); chk("a_empty_cnt", 32'(cnt_a), 0);
        chk("a_empty_ae", 32'(ae_a), 1); chk("a_empty_wok", 32'(wok_a), 1);
        // A: refill, then simultaneous read/write while full
        for (int i = 0; i < 4; i++) begin
            nx(); w_a = 1; wd_a = data_t'(8'h40 + i); qa.push_back(wd_a);
        end
        nx(); w_a = 1; r_a = 1; wd_a = 8'h99;
        @(negedge clk);
        chk("a_full_wok", 32'(wok_a), 0); chk("a_full_rok", 32'(rok_a), 1); chk("a_full_cnt", 32'(cnt_a), 4);
        nx(); w_a = 0;
        @(negedge clk);
        chk("a_after_cnt", 32'(cnt_a), 3); chk("a_after_wok", 32'(wok_a), 1);
        repeat (3) nx();
        r_a = 0;
        @(negedge clk);
        chk("a_drain_cnt", 32'(cnt_a), 0);
`ifdef HPDCACHE_FIFO_PRELOAD_STATS_EN
        chk("a_err_set", 32'(err_a), 1); chk("a_max", 32'(max_a), 4);
`endif
        // A: flush overrides r/w at count 1
        nx(); w_a = 1; wd_a = 8'h55;
        nx(); w_a = 1; r_a = 1; fl_a = 1; wd_a = 8'h66;
        @(negedge clk);
        chk("a_fl_rok", 32'(rok_a), 0); chk("a_fl_wok", 32'(wok_a), 0); chk("a_fl_cnt", 32'(cnt_a), 1);
        nx(); w_a = 0; r_a = 0; fl_a = 0;
        @(negedge clk);
        chk("a_postfl_cnt", 32'(cnt_a), 4); chk("a_postfl_rd", 32'(rd_a), 0);
`ifdef HPDCACHE_FIFO_PRELOAD_STATS_EN
        chk("a_err_clr", 32'(err_a), 0);
`endif

        // B: partial preload then two writes
        qb.push_back(8'h10); qb.push_back(8'h11); qb.push_back(8'h0A); qb.push_back(8'h0B);
        nx(); w_b = 1; wd_b = 8'h0A;
        nx(); wd_b = 8'h0B;
        nx(); w_b = 0;
        @(negedge clk);
        chk("b_full_cnt", 32'(cnt_b), 4); chk("b_full_wok", 32'(wok_b), 0);
`ifdef HPDCACHE_FIFO_PRELOAD_STATS_EN
        chk("b_max4", 32'(max_b), 4);
`endif
        r_b = 1;
        repeat (4) nx();
        r_b = 0;
        // B: write/read pairs wrap both pointers
        for (int i = 0; i < 4; i++) begin
            w_b = 1; wd_b = data_t'(8'hC0 + i); qb.push_back(wd_b);
            nx(); w_b = 0; r_b = 1;
            @(negedge clk);
            chk("b_pair_cnt", 32'(cnt_b), 1); chk("b_pair_ae", 32'(ae_b), 1);
            nx(); r_b = 0;
        end
        @(negedge clk);
        chk("b_end_cnt", 32'(cnt_b), 0);
        nx(); fl_b = 1;
        nx(); fl_b = 0;
        @(negedge clk);
        chk("b_fl_cnt", 32'(cnt_b), 2); chk("b_fl_rd", 32'(rd_b), 8'h10);
`ifdef HPDCACHE_FIFO_PRELOAD_STATS_EN
        chk("b_max_clr", 32'(max_b), 2); chk("b_err", 32'(err_b), 0);
`endif

        // C: feed-through bypass on empty
        nx(); w_c = 1; r_c = 1; wd_c = 8'h05; qc.push_back(8'h05);
        @(negedge clk);
        chk("c_ft_rok", 32'(rok_c), 1); chk("c_ft_cnt", 32'(cnt_c), 0);
        nx(); r_c = 0; wd_c = 8'h06;
        @(negedge clk);
        chk("c_bypass_cnt", 32'(cnt_c), 0); chk("c_w_rok", 32'(rok_c), 1); chk("c_w_rd", 32'(rd_c), 8'h06);
        nx(); w_c = 0;
        @(negedge clk);
        chk("c_stored_cnt", 32'(cnt_c), 1); chk("c_stored_rd", 32'(rd_c), 8'h06);
        qc.push_back(8'h06);
        nx(); r_c = 1;
        nx(); r_c = 0;
        @(negedge clk);
        chk("c_end_cnt", 32'(cnt_c), 0); chk("c_end_rok", 32'(rok_c), 0);

        chk("qa_drained", 32'(qa.size()), 0);
        chk("qb_drained", 32'(qb.size()), 0);
        chk("qc_drained", 32'(qc.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hpdcache_fifo_reg_preload.md
Name: hpdcache_fifo_reg_preload

Overview:
- Register-based FIFO whose storage is preloaded from an input vector at reset and on a synchronous flush.
- Configurable initial occupancy (partial preload), occupancy counter, almost-empty flag and optional empty feed-through.
- Intended for free-lists of IDs, tags or credits in the HPDcache, e.g. MSHR/RTAB slot pools, where only part of the pool is free at start.

Parameters:
- FIFO_DEPTH, 4, number of entries; must be >= 2.
- fifo_data_t, logic, entry type.
- INIT_COUNT, FIFO_DEPTH, entries valid after reset/flush; 0..FIFO_DEPTH.
- AEMPTY_THRESH, 1, aempty_o asserted when count_o <= AEMPTY_THRESH.
- FEED_THROUGH, 0, 1: a write to an empty FIFO is readable in the same cycle.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  synchronous reload to the post-reset state.
- w_i  in  1  write request.
- wok_o  out  1  write can be accepted.
- wdata_i  in  fifo_data_t  write data.
- r_i  in  1  read request.
- rok_o  out  1  read data valid.
- rdata_o  out  fifo_data_t  head entry.
- initial_value_i  in  fifo_data_t[FIFO_DEPTH]  preload contents; entry i goes to slot i.
- count_o  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- aempty_o  out  1  almost-empty flag.

Behaviour:
- State: rptr, wptr ($clog2(FIFO_DEPTH) bits) and an occupancy counter. The counter replaces the crossover bit.
  - empty = (count==0); full = (count==FIFO_DEPTH).
- Reset (async) and flush (sync, next edge):
  - rptr=0, wptr=INIT_COUNT mod FIFO_DEPTH, count=INIT_COUNT.
  - Storage is loaded from initial_value_i on every clock edge where rst_ni==0 or flush_i==1.
  - Storage is not asynchronously reset. Slots >= INIT_COUNT are loaded too; these are don't-care.
- Outputs after reset:
  - count_o=INIT_COUNT.
  - rok_o=(INIT_COUNT>0).
  - wok_o=(INIT_COUNT<FIFO_DEPTH).
  - aempty_o=(INIT_COUNT<=AEMPTY_THRESH).
  - rdata_o=initial_value_i[0] once loaded.
- Flush priority:
  - flush_i overrides r_i and w_i: no read or write executes in that cycle.
  - wok_o and rok_o are forced to 0 while flush_i is high.
- Handshake: wexec = w_i & wok_o; rexec = r_i & rok_o. Both can execute in the same cycle.
- wok_o = ~full & ~flush_i.
  - A full FIFO does not accept a write even when a read executes in the same cycle (no combinational r-to-wok path).
- rok_o:
  - FEED_THROUGH=0: rok_o = ~empty & ~flush_i.
  - FEED_THROUGH=1: rok_o = (~empty | w_i) & ~flush_i.
  - When empty with w_i=1: rdata_o=wdata_i. If r_i is also 1, the entry bypasses storage; pointers and count are unchanged.
- Pointer update:
  - Each pointer increments on its exec signal and wraps from FIFO_DEPTH-1 to 0. FIFO_DEPTH need not be a power of 2.
- Count update: +1 on wexec only; -1 on rexec only; unchanged on both or neither.
- rdata_o = mem[rptr], combinational, zero read latency.
- Write latency: data is visible at rdata_o the cycle after the write when the FIFO was empty (FEED_THROUGH=0).
- count_o and aempty_o are registered-state derived (combinational from count); no dependence on r_i or w_i.
- Assertions (translate_off):
  - No wexec when full; no rexec when empty without feed-through.
  - count <= FIFO_DEPTH.
  - (wptr - rptr) mod FIFO_DEPTH == count mod FIFO_DEPTH.
  - Elaboration check INIT_COUNT <= FIFO_DEPTH.

Optional Feature:
- Macro HPDCACHE_FIFO_PRELOAD_STATS_EN.
- When defined, adds two ports:
  - max_count_o [$clog2(FIFO_DEPTH+1)] out: high-water mark of count, reset/flush to INIT_COUNT.
  - err_o [1] out: sticky, set when w_i=1 with wok_o=0 and flush_i=0 (overflow attempt), or r_i=1 with rok_o=0 and flush_i=0 (underflow attempt). Cleared only by reset or flush.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset with FIFO_DEPTH=4, INIT_COUNT=4, initial_value_i={3,2,1,0}: rok_o=1, wok_o=0, count_o=4. Four consecutive reads return 0,1,2,3; then rok_o=0, count_o=0, aempty_o=1.
- INIT_COUNT=2, DEPTH=4: count_o=2, wok_o=1. Write 0xA then 0xB; reads return slot0, slot1, 0xA, 0xB. Pointer wrap confirmed after a further 4 write/read pairs.
- Full FIFO, r_i=1 and w_i=1 in the same cycle: the read executes, the write is rejected (wok_o=0), count goes 4->3. Next cycle wok_o=1.
- FEED_THROUGH=1, empty, w_i=r_i=1 with wdata_i=0x5: rok_o=1, rdata_o=0x5 in the same cycle; count_o stays 0.
- Mid-stream flush_i at count=1 with w_i=r_i=1: no execution, rok_o=wok_o=0 that cycle. Next cycle count_o=INIT_COUNT and rdata_o=initial_value_i[0].
- With HPDCACHE_FIFO_PRELOAD_STATS_EN: write into a full FIFO sets err_o=1 and it stays set. max_count_o tracks the peak of 4, and both clear on flush.
